subservient_wb_loader: RTL and testbench
========================================

SUBSERVIENT_WB_LOADER -- requirements
Module: subservient_wb_loader

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: aw, 8, byte-address width; Wishbone word address is [aw-1:2].
REQ-003 Port: i_clk  in  1  rising-edge clock.
REQ-004 Port: i_rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: i_start  in  1  one-cycle pulse that begins a load at i_base_adr.
REQ-006 Port: i_base_adr  in  aw-2  first word address of the load.
REQ-007 Port: i_data  in  8  byte-stream data.
REQ-008 Port: i_valid  in  1  byte-stream valid.
REQ-009 Port: i_last  in  1  qualifies the final byte of the stream.
REQ-010 Port: o_ready  out  1  byte-stream ready.
REQ-011 Port: o_wb_adr  out  aw-2  Wishbone word address.
REQ-012 Port: o_wb_dat  out  32  Wishbone write data.
REQ-013 Port: o_wb_sel  out  4  Wishbone byte selects.
REQ-014 Port: o_wb_we  out  1  Wishbone write enable.
REQ-015 Port: o_wb_stb  out  1  Wishbone strobe (cycle implied).
REQ-016 Port: i_wb_rdt  in  32  Wishbone read data.
REQ-017 Port: i_wb_ack  in  1  Wishbone acknowledge.
REQ-018 Port: o_busy  out  1  high in every state except IDLE.
REQ-019 Port: o_done  out  1  one-cycle pulse when the load completes.
REQ-020 Port: o_err  out  1  sticky readback-mismatch flag.

Function
REQ-021 States SHALL be IDLE, COLLECT, WRITE, VERIFY (macro only) and DONE.
REQ-022 In IDLE, i_start SHALL load o_wb_adr with i_base_adr, clear the byte index and o_err, and enter COLLECT next cycle; i_start outside IDLE SHALL be ignored.
REQ-023 A byte SHALL be accepted only when i_valid and o_ready are both high; o_ready SHALL be high only in COLLECT.
REQ-024 Byte n of a word (n = 0..3) SHALL be stored little-endian in o_wb_dat[8n+:8] and SHALL set o_wb_sel[n].
REQ-025 Acceptance of byte index 3, or of any byte with i_last high, SHALL move to WRITE with o_wb_stb=1 and o_wb_we=1 in the following cycle.
REQ-026 A partial final word SHALL be written with o_wb_sel containing only the collected bytes; unselected o_wb_dat bytes SHALL be 0.
REQ-027 o_wb_stb, o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we SHALL be held stable until i_wb_ack is sampled high; o_wb_stb SHALL be low the cycle after ack.
REQ-028 i_wb_ack sampled while o_wb_stb is low SHALL be ignored.
REQ-029 After a completed write (and verify, if built in), o_wb_adr SHALL increment by 1, wrapping modulo 2^(aw-2), and the byte index and o_wb_sel SHALL clear.
REQ-030 After the word holding the i_last byte completes, the state SHALL be DONE for exactly one cycle with o_done=1, then IDLE.
REQ-031 Back-pressure SHALL be absolute: no byte SHALL be accepted in WRITE, VERIFY or DONE.

Reset
REQ-032 Assertion of i_rst_n=0 SHALL immediately force IDLE, o_wb_stb=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_ready=0, o_busy=0, o_done=0 and o_err=0, including mid-transaction; partial words SHALL be discarded.
REQ-033 Release of reset SHALL be synchronous to i_clk.

Configuration
REQ-034 The macro SUBSERVIENT_LOADER_VERIFY_EN SHALL control readback verification.
REQ-035 With the macro defined, each write ack SHALL be followed next cycle by VERIFY: o_wb_stb=1, o_wb_we=0, o_wb_sel=4'hf, same o_wb_adr; on ack, bytes enabled in the written sel that differ from i_wb_rdt SHALL set o_err, which holds until the next i_start or reset.
REQ-036 With the macro undefined, VERIFY SHALL not exist, no reads SHALL be issued, and o_err SHALL be constant 0.

Verification
REQ-037 i_start, i_base_adr=0x10, bytes 11,22,33,44 (last on 44), ack after 3 cycles -> one write adr 0x10, dat 0x44332211, sel 4'hf; o_done one cycle; o_busy low afterwards.
REQ-038 Bytes AA,BB,CC,DD,EE (last on EE), base 0x00 -> writes adr 0x00 dat 0xDDCCBBAA sel 4'hf, then adr 0x01 dat 0x000000EE sel 4'h1.
REQ-039 aw=8, base 0x3F, eight bytes -> second write at adr 0x00 (wrap).
REQ-040 Reset asserted while o_wb_stb=1 awaiting ack -> o_wb_stb, o_busy, o_ready go 0 immediately; a later stray ack causes no state change.
REQ-041 VERIFY_EN defined, write 0x44332211 sel 4'hf, read returns 0x44332200 -> o_err=1 through o_done; next i_start clears it.
REQ-042 i_start pulsed while in WRITE -> ignored; o_wb_adr unchanged, single o_done at end of the original load.

Source files
------------

// File: rtl/subservient_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : subservient_wb_loader
// Description : Packs an 8-bit valid/ready byte stream into little-endian
//               32-bit words. Each word is written to a Wishbone bus at
//               consecutive word addresses, starting from i_base_adr.
//               A partial final word is written with only the collected byte
//               lanes selected.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: SUBSERVIENT_LOADER_VERIFY_EN
//               When defined, every write is followed by a readback of the
//               same word. A mismatch on any written byte sets the sticky
//               o_err flag.
// ----------------------------------------------------------------------------
// Ports
//   i_clk       in   1      rising-edge clock
//   i_rst_n     in   1      asynchronous active-low reset
//   i_start     in   1      pulse in IDLE that begins a load at i_base_adr
//   i_base_adr  in   aw-2   first word address of the load
//   i_data      in   8      byte-stream data
//   i_valid     in   1      byte-stream valid
//   i_last      in   1      marks the final byte of the stream
//   o_ready     out  1      byte-stream ready (high only while collecting)
//   o_wb_adr    out  aw-2   Wishbone word address
//   o_wb_dat    out  32     Wishbone write data
//   o_wb_sel    out  4      Wishbone byte selects
//   o_wb_we     out  1      Wishbone write enable
//   o_wb_stb    out  1      Wishbone strobe (cycle implied)
//   i_wb_rdt    in   32     Wishbone read data
//   i_wb_ack    in   1      Wishbone acknowledge
//   o_busy      out  1      high whenever the loader is not idle
//   o_done      out  1      one-cycle pulse when the load completes
//   o_err       out  1      sticky readback-mismatch flag
// ============================================================================
module subservient_wb_loader #(
  parameter int aw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [aw-3:0] i_base_adr,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  input  logic          i_last,
  output logic          o_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [aw-3:0] c_ADR_ONE = {{(aw-3){1'b0}}, 1'b1};

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_VERIFY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd4
  } state_t;
`endif

  state_t        r_state;
  state_t        w_next;

  logic [aw-3:0] r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic [1:0]    r_idx;
  logic          r_last;   // current word holds the stream's final byte

  logic          w_start;
  logic          w_accept;
  logic          w_word_done;

  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_accept = (r_state == S_COLLECT) && i_valid;

  // A word is finished once its final bus transaction has been acknowledged.
  // The acknowledge is only taken into account while the strobe is driven.
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
  assign w_word_done = (r_state == S_VERIFY) && i_wb_ack;
`else
  assign w_word_done = (r_state == S_WRITE) && i_wb_ack;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (i_valid && ((r_idx == 2'd3) || i_last)) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (i_wb_ack) begin
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
          w_next = S_VERIFY;
`else
          w_next = r_last ? S_DONE : S_COLLECT;
`endif
        end
      end
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (i_wb_ack) w_next = r_last ? S_DONE : S_COLLECT;
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Word assembly and address tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_start) begin
      r_adr  <= i_base_adr;
      r_dat  <= '0;
      r_sel  <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_dat[{r_idx, 3'b000} +: 8] <= i_data;
      r_sel[r_idx]                <= 1'b1;
      r_idx                       <= r_idx + 2'd1;
      r_last                      <= i_last;
    end else if (w_word_done) begin
      // Clearing the data keeps unselected lanes of a partial word at zero.
      r_adr <= r_adr + c_ADR_ONE;
      r_dat <= '0;
      r_sel <= '0;
      r_idx <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Readback check
  // --------------------------------------------------------------------------
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
  logic r_err;
  logic w_mismatch;

  // Only the lanes that were actually written are compared.
  always_comb begin
    w_mismatch = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (r_sel[n] && (r_dat[8*n +: 8] != i_wb_rdt[8*n +: 8])) w_mismatch = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_word_done && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign o_err    = r_err;
  assign o_wb_sel = (r_state == S_VERIFY) ? 4'hf : r_sel;
  assign o_wb_stb = (r_state == S_WRITE) || (r_state == S_VERIFY);
`else
  // Read data has no consumer when readback is not built in.
  logic w_unused_rdt;
  assign w_unused_rdt = ^i_wb_rdt;

  assign o_err    = 1'b0;
  assign o_wb_sel = r_sel;
  assign o_wb_stb = (r_state == S_WRITE);
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_ready  = (r_state == S_COLLECT);
  assign o_wb_adr = r_adr;
  assign o_wb_dat = r_dat;
  assign o_wb_we  = (r_state == S_WRITE);
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_subservient_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_subservient_wb_loader
// Description : Directed self-checking bench for subservient_wb_loader.
//               Stimulus is applied and outputs are sampled on the falling
//               clock edge. Readback scenarios are included when
//               SUBSERVIENT_LOADER_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subservient_wb_loader;

  localparam int aw = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [aw-3:0] i_base_adr;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [aw-3:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_stb;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  subservient_wb_loader #(.aw(aw)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_base_adr (i_base_adr),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_stb   (o_wb_stb),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking inside, only status flags returned)
  // --------------------------------------------------------------------------
  task automatic do_start(input logic [aw-3:0] base);
    i_start    = 1'b1;
    i_base_adr = base;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output bit ok);
    int n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = o_ready;
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Waits for a write strobe, holds ack off for 'delay' cycles, then acks.
  // With readback built in, the following read is answered with the written
  // data XOR 'corrupt'.
  task automatic wb_cycle(input int delay, input logic [31:0] corrupt,
                          output logic [aw-3:0] adr, output logic [31:0] dat,
                          output logic [3:0] sel, output logic we,
                          output bit ok, output bit stable);
    int n = 0;
    ok = 1'b0; stable = 1'b1;
    adr = '0; dat = '0; sel = '0; we = 1'b0;
    while (!o_wb_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_wb_stb) begin
      ok = 1'b1;
      adr = o_wb_adr; dat = o_wb_dat; sel = o_wb_sel; we = o_wb_we;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (!o_wb_stb || o_wb_adr != adr || o_wb_dat != dat ||
            o_wb_sel != sel || o_wb_we != we) stable = 1'b0;
      end
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
      if (o_wb_stb && !o_wb_we) begin
        i_wb_rdt = dat ^ corrupt;
        i_wb_ack = 1'b1;
        @(negedge clk);
        i_wb_ack = 1'b0;
        i_wb_rdt = '0;
      end else begin
        ok = 1'b0;
      end
`endif
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_wb_stb !== 1'b0) $display("FAIL rst_stb: got %b want 0", o_wb_stb); else n_pass++;
    n_checks++; if (o_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", o_ready); else n_pass++;
    n_checks++; if ({o_wb_adr, o_wb_dat, o_wb_sel} !== '0) $display("FAIL rst_bus: got adr %h dat %h sel %h want 0", o_wb_adr, o_wb_dat, o_wb_sel); else n_pass++;
    n_checks++; if ({o_done, o_err, o_wb_we} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {o_done, o_err, o_wb_we}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_ready !== 1'b0) $display("FAIL rst_idle: got busy %b ready %b want 0 0", o_busy, o_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [aw-3:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    bit ok, stable, all_ok;
    all_ok = 1'b1;
    do_start(6'h10);
    n_checks++; if (o_busy !== 1'b1 || o_ready !== 1'b1) $display("FAIL basic_collect: got busy %b ready %b want 1 1", o_busy, o_ready); else n_pass++;
    send_byte(8'h11, 1'b0, ok); all_ok &= ok;
    send_byte(8'h22, 1'b0, ok); all_ok &= ok;
    send_byte(8'h33, 1'b0, ok); all_ok &= ok;
    send_byte(8'h44, 1'b1, ok); all_ok &= ok;
    n_checks++; if (all_ok !== 1'b1) $display("FAIL basic_bytes: got accepted %b want 1", all_ok); else n_pass++;
    n_checks++; if (o_ready !== 1'b0) $display("FAIL basic_backpressure: got ready %b want 0", o_ready); else n_pass++;
    wb_cycle(3, 32'h0, adr, dat, sel, we, ok, stable);
    n_checks++; if (ok !== 1'b1) $display("FAIL basic_stb: got %b want 1", ok); else n_pass++;
    n_checks++; if (adr !== 6'h10) $display("FAIL basic_adr: got %h want 10", adr); else n_pass++;
    n_checks++; if (dat !== 32'h44332211) $display("FAIL basic_dat: got %h want 44332211", dat); else n_pass++;
    n_checks++; if (sel !== 4'hf || we !== 1'b1) $display("FAIL basic_sel_we: got %h %b want f 1", sel, we); else n_pass++;
    n_checks++; if (stable !== 1'b1) $display("FAIL basic_stable: got %b want 1", stable); else n_pass++;
    n_checks++; if (o_done !== 1'b1 || o_wb_stb !== 1'b0) $display("FAIL basic_done: got done %b stb %b want 1 0", o_done, o_wb_stb); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) $display("FAIL basic_idle: got done %b busy %b want 0 0", o_done, o_busy); else n_pass++;
`ifndef SUBSERVIENT_LOADER_VERIFY_EN
    n_checks++; if (o_err !== 1'b0) $display("FAIL basic_err: got %b want 0", o_err); else n_pass++;
`endif
  endtask

  task automatic test_partial();
    logic [aw-3:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    bit ok, stable, all_ok;
    all_ok = 1'b1;
    do_start(6'h00);
    send_byte(8'hAA, 1'b0, ok); all_ok &= ok;
    send_byte(8'hBB, 1'b0, ok); all_ok &= ok;
    send_byte(8'hCC, 1'b0, ok); all_ok &= ok;
    send_byte(8'hDD, 1'b0, ok); all_ok &= ok;
    wb_cycle(1, 32'h0, adr, dat, sel, we, ok, stable);
    n_checks++; if (ok !== 1'b1 || adr !== 6'h00 || dat !== 32'hDDCCBBAA || sel !== 4'hf) $display("FAIL part_w0: got ok %b adr %h dat %h sel %h want 1 00 ddccbbaa f", ok, adr, dat, sel); else n_pass++;
    n_checks++; if (o_ready !== 1'b1 || o_wb_sel !== 4'h0 || o_wb_adr !== 6'h01) $display("FAIL part_next: got ready %b sel %h adr %h want 1 0 01", o_ready, o_wb_sel, o_wb_adr); else n_pass++;
    send_byte(8'hEE, 1'b1, ok); all_ok &= ok;
    wb_cycle(0, 32'h0, adr, dat, sel, we, ok, stable);
    n_checks++; if (ok !== 1'b1 || adr !== 6'h01 || dat !== 32'h000000EE || sel !== 4'h1) $display("FAIL part_w1: got ok %b adr %h dat %h sel %h want 1 01 000000ee 1", ok, adr, dat, sel); else n_pass++;
    n_checks++; if (o_done !== 1'b1 || all_ok !== 1'b1) $display("FAIL part_done: got done %b bytes %b want 1 1", o_done, all_ok); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [aw-3:0] adr0, adr1; logic [31:0] dat0, dat1; logic [3:0] sel; logic we;
    bit ok0, ok1, ok, stable;
    do_start(6'h3F);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, ok);
    wb_cycle(0, 32'h0, adr0, dat0, sel, we, ok0, stable);
    for (int i = 5; i <= 8; i++) send_byte(8'(i), (i == 8), ok);
    wb_cycle(2, 32'h0, adr1, dat1, sel, we, ok1, stable);
    n_checks++; if (ok0 !== 1'b1 || adr0 !== 6'h3F || dat0 !== 32'h04030201) $display("FAIL wrap_w0: got ok %b adr %h dat %h want 1 3f 04030201", ok0, adr0, dat0); else n_pass++;
    n_checks++; if (ok1 !== 1'b1 || adr1 !== 6'h00 || dat1 !== 32'h08070605) $display("FAIL wrap_w1: got ok %b adr %h dat %h want 1 00 08070605", ok1, adr1, dat1); else n_pass++;
    n_checks++; if (o_done !== 1'b1) $display("FAIL wrap_done: got %b want 1", o_done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [aw-3:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    bit ok, stable;
    do_start(6'h05);
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), (i == 3), ok);
    n_checks++; if (o_wb_stb !== 1'b1) $display("FAIL rmid_stb_before: got %b want 1", o_wb_stb); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_wb_stb !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) $display("FAIL rmid_async: got stb %b busy %b ready %b want 0 0 0", o_wb_stb, o_busy, o_ready); else n_pass++;
    n_checks++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== '0) $display("FAIL rmid_bus: got adr %h dat %h sel %h we %b want 0", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_wb_stb !== 1'b0 || o_done !== 1'b0) $display("FAIL rmid_stray_ack: got busy %b stb %b done %b want 0 0 0", o_busy, o_wb_stb, o_done); else n_pass++;
    // A partial word interrupted by reset must not leak into the next load.
    do_start(6'h08);
    send_byte(8'hAA, 1'b0, ok);
    send_byte(8'hBB, 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(6'h09);
    send_byte(8'hCC, 1'b1, ok);
    wb_cycle(0, 32'h0, adr, dat, sel, we, ok, stable);
    n_checks++; if (ok !== 1'b1 || adr !== 6'h09 || dat !== 32'h000000CC || sel !== 4'h1) $display("FAIL rmid_discard: got ok %b adr %h dat %h sel %h want 1 09 000000cc 1", ok, adr, dat, sel); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [aw-3:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    bit ok, stable;
    int dones;
    do_start(6'h05);
    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), (i == 3), ok);
    do_start(6'h20);
    n_checks++; if (o_wb_stb !== 1'b1 || o_wb_adr !== 6'h05) $display("FAIL sign_hold: got stb %b adr %h want 1 05", o_wb_stb, o_wb_adr); else n_pass++;
    wb_cycle(1, 32'h0, adr, dat, sel, we, ok, stable);
    n_checks++; if (ok !== 1'b1 || adr !== 6'h05 || dat !== 32'h63626160) $display("FAIL sign_write: got ok %b adr %h dat %h want 1 05 63626160", ok, adr, dat); else n_pass++;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 1) $display("FAIL sign_done_count: got %0d want 1", dones); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL sign_idle: got busy %b want 0", o_busy); else n_pass++;
  endtask

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
  task automatic test_err();
    bit ok;
    int n;
    do_start(6'h10);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1), (i == 3), ok);
    n = 0;
    while (!o_wb_stb && n < 50) begin @(negedge clk); n++; end
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    n_checks++; if (o_wb_stb !== 1'b1 || o_wb_we !== 1'b0 || o_wb_sel !== 4'hf || o_wb_adr !== 6'h10) $display("FAIL err_read: got stb %b we %b sel %h adr %h want 1 0 f 10", o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr); else n_pass++;
    i_wb_rdt = 32'h44332200;
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    i_wb_rdt = '0;
    n_checks++; if (o_done !== 1'b1 || o_err !== 1'b1) $display("FAIL err_set: got done %b err %b want 1 1", o_done, o_err); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", o_err); else n_pass++;
    do_start(6'h00);
    n_checks++; if (o_err !== 1'b0) $display("FAIL err_clear: got %b want 0", o_err); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_base_adr = '0;
    i_data     = '0;
    i_valid    = 1'b0;
    i_last     = 1'b0;
    i_wb_rdt   = '0;
    i_wb_ack   = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
